// File: rtl/register_file_mp.sv
// Multi-port register file with per-port write width, write-to-read bypass
// and a pending-write scoreboard so decode can stall on outstanding producers.
module register_file_mp #(
    parameter int REG_NUMBER        = 32,
    parameter int REG_ADDR_WIDTH    = $clog2(REG_NUMBER),
    parameter int REG_WIDTH_IN_BYTE = 4,
    parameter int REG_WIDTH_IN_BIT  = REG_WIDTH_IN_BYTE * 8,
    parameter int NUM_READ_PORTS    = 2,
    parameter int NUM_WRITE_PORTS   = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0]     read_addr,
    output logic [NUM_READ_PORTS*REG_WIDTH_IN_BIT-1:0]   read_data,
    output logic [NUM_READ_PORTS-1:0]                    read_pending,
    input  logic                                         issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0]                    issue_addr,
    input  logic [NUM_WRITE_PORTS-1:0]                   write_enable,
    input  logic [NUM_WRITE_PORTS*4-1:0]                 write_width,
    input  logic [NUM_WRITE_PORTS-1:0]                   write_sign_ext,
    input  logic [NUM_WRITE_PORTS*REG_ADDR_WIDTH-1:0]    write_addr,
    input  logic [NUM_WRITE_PORTS*REG_WIDTH_IN_BIT-1:0]  write_data,
    output logic [$clog2(REG_NUMBER+1)-1:0]              pending_count,
    output logic                                         write_error
);
    localparam int AW = REG_ADDR_WIDTH;
    localparam int W  = REG_WIDTH_IN_BIT;
    localparam int NR = NUM_READ_PORTS;
    localparam int NW = NUM_WRITE_PORTS;
    localparam int CW = $clog2(REG_NUMBER + 1);

    logic [W-1:0]          regs [REG_NUMBER];
    logic [REG_NUMBER-1:0] pending;
    logic [REG_NUMBER-1:0] pending_next;
    logic [CW-1:0]         count_next;

    logic [AW-1:0] w_addr  [NW];
    logic [3:0]    w_width [NW];
    logic [W-1:0]  w_data  [NW];
    logic [W-1:0]  w_value [NW];
    logic [NW-1:0] width_ok;
    logic [NW-1:0] w_hit;
    logic [NW-1:0] sign_bit;
    logic [AW-1:0] r_addr  [NR];

    // w_hit marks a port whose write actually lands: legal width, non-zero target
    always_comb begin
        sign_bit = '0;
        for (int p = 0; p < NW; p++) begin
            w_addr[p]   = write_addr[p*AW +: AW];
            w_width[p]  = write_width[p*4 +: 4];
            w_data[p]   = write_data[p*W +: W];
            width_ok[p] = (w_width[p] == 4'd1 || w_width[p] == 4'd2 || w_width[p] == 4'd4)
                          && (int'(w_width[p]) <= REG_WIDTH_IN_BYTE);
            w_hit[p]    = write_enable[p] && width_ok[p] && (w_addr[p] != '0)
                          && (int'(w_addr[p]) < REG_NUMBER);
            for (int b = 0; b < W; b++) begin
                if (b == int'(w_width[p]) * 8 - 1)
                    sign_bit[p] = write_sign_ext[p] & w_data[p][b];
            end
            for (int b = 0; b < W; b++) begin
                w_value[p][b] = (b < int'(w_width[p]) * 8) ? w_data[p][b] : sign_bit[p];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            r_addr[k] = read_addr[k*AW +: AW];
        end
    end

    // Later write ports override earlier ones, giving highest-index priority
    always_comb begin
        read_data    = '0;
        read_pending = '0;
        for (int k = 0; k < NR; k++) begin
            if (r_addr[k] != '0 && int'(r_addr[k]) < REG_NUMBER) begin
                read_data[k*W +: W] = regs[r_addr[k]];
                read_pending[k]     = pending[r_addr[k]];
                for (int p = 0; p < NW; p++) begin
                    if (w_hit[p] && w_addr[p] == r_addr[k]) begin
                        read_data[k*W +: W] = w_value[p];
                        read_pending[k]     = 1'b0;
                    end
                end
            end
        end
    end

    // Issue is applied after the clears so a same-cycle new producer keeps the bit set
    always_comb begin
        pending_next = pending;
        for (int p = 0; p < NW; p++) begin
            if (w_hit[p])
                pending_next[w_addr[p]] = 1'b0;
        end
        if (issue_valid && issue_addr != '0 && int'(issue_addr) < REG_NUMBER)
            pending_next[issue_addr] = 1'b1;
        count_next = '0;
        for (int r = 0; r < REG_NUMBER; r++) begin
            count_next = count_next + CW'(pending_next[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < REG_NUMBER; r++) begin
                regs[r] <= '0;
            end
            pending       <= '0;
            pending_count <= '0;
            write_error   <= 1'b0;
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (w_hit[p])
                    regs[w_addr[p]] <= w_value[p];
            end
            pending       <= pending_next;
            pending_count <= count_next;
            write_error   <= |(write_enable & ~width_ok);
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed scenarios plus randomized
// traffic compared against a behavioural register/scoreboard model.
module tb_register_file_mp;
    localparam int AW = 5;
    localparam int W  = 32;
    localparam int NR = 2;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] ra [NR];
    logic          iv;
    logic [AW-1:0] ia;
    logic          we [NW];
    logic [3:0]    ww [NW];
    logic          ws [NW];
    logic [AW-1:0] wa [NW];
    logic [W-1:0]  wd [NW];

    logic [NR*AW-1:0] read_addr;
    logic [NR*W-1:0]  read_data;
    logic [NR-1:0]    read_pending;
    logic [NW-1:0]    write_enable;
    logic [NW*4-1:0]  write_width;
    logic [NW-1:0]    write_sign_ext;
    logic [NW*AW-1:0] write_addr;
    logic [NW*W-1:0]  write_data;
    logic [5:0]       pending_count;
    logic             write_error;

    assign read_addr      = {ra[1], ra[0]};
    assign write_enable   = {we[1], we[0]};
    assign write_width    = {ww[1], ww[0]};
    assign write_sign_ext = {ws[1], ws[0]};
    assign write_addr     = {wa[1], wa[0]};
    assign write_data     = {wd[1], wd[0]};

    register_file_mp dut (
        .clk(clk), .reset(reset),
        .read_addr(read_addr), .read_data(read_data), .read_pending(read_pending),
        .issue_valid(iv), .issue_addr(ia),
        .write_enable(write_enable), .write_width(write_width),
        .write_sign_ext(write_sign_ext), .write_addr(write_addr), .write_data(write_data),
        .pending_count(pending_count), .write_error(write_error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    int          m_count;
    bit          m_err;

    function automatic logic [31:0] rd(input int k);
        return read_data[k*W +: W];
    endfunction

    function automatic bit legal_w(input logic [3:0] w);
        return (w == 4'd1 || w == 4'd2 || w == 4'd4);
    endfunction

    function automatic logic [31:0] eff(input logic [3:0] w, input logic [31:0] d, input logic s);
        logic [31:0] v;
        case (w)
            4'd1: begin v = d & 32'h0000_00FF; if (s && d[7])  v = v | 32'hFFFF_FF00; end
            4'd2: begin v = d & 32'h0000_FFFF; if (s && d[15]) v = v | 32'hFFFF_0000; end
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic bit writes_to(input int p, input logic [4:0] a);
        return we[p] && legal_w(ww[p]) && wa[p] == a && a != 5'd0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = m_regs[a];
        for (int p = 0; p < NW; p++)
            if (writes_to(p, a)) v = eff(ww[p], wd[p], ws[p]);
        return v;
    endfunction

    function automatic bit exp_pend(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        for (int p = 0; p < NW; p++)
            if (writes_to(p, a)) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic idle();
        reset = 1'b1;
        iv = 1'b0; ia = '0;
        for (int p = 0; p < NW; p++) begin
            we[p] = 1'b0; ww[p] = 4'd4; ws[p] = 1'b0; wa[p] = '0; wd[p] = '0;
        end
        ra[0] = '0; ra[1] = '0;
    endtask

    task automatic set_wr(input int p, input logic [3:0] w, input logic s,
                          input logic [4:0] a, input logic [31:0] d);
        we[p] = 1'b1; ww[p] = w; ws[p] = s; wa[p] = a; wd[p] = d;
    endtask

    // Advance one clock, updating the model from the inputs held across the edge
    task automatic tick();
        logic [31:0] nregs [32];
        bit          npend [32];
        int          ncount;
        bit          nerr;
        nregs = m_regs;
        npend = m_pend;
        nerr  = 1'b0;
        if (!reset) begin
            for (int r = 0; r < 32; r++) begin nregs[r] = '0; npend[r] = 1'b0; end
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (we[p] && !legal_w(ww[p])) nerr = 1'b1;
                else if (writes_to(p, wa[p])) begin
                    nregs[wa[p]] = eff(ww[p], wd[p], ws[p]);
                    npend[wa[p]] = 1'b0;
                end
            end
            if (iv && ia != 5'd0) npend[ia] = 1'b1;
        end
        ncount = 0;
        for (int r = 0; r < 32; r++) ncount += int'(npend[r]);
        @(posedge clk);
        m_regs = nregs; m_pend = npend; m_count = ncount; m_err = nerr;
        #1;
    endtask

    function automatic logic [3:0] rand_width();
        case ($urandom_range(0, 7))
            0: return 4'd1;
            1: return 4'd2;
            5: return 4'd3;
            6: return 4'd0;
            7: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    task automatic test_reset();
        for (int c = 0; c < 6; c++) begin
            idle();
            reset = (c >= 2 && c != 4);
            for (int p = 0; p < NW; p++)
                set_wr(p, rand_width(), 1'($urandom), 5'($urandom), $urandom);
            iv = 1'b1; ia = 5'($urandom_range(1, 31));
            tick();
        end
        idle();
        reset = 1'b0;
        set_wr(1, 4'd4, 1'b0, 5'd12, 32'hCAFE_F00D);
        iv = 1'b1; ia = 5'd12;
        tick();
        idle();
        vectors++;
        if (pending_count !== 6'd0) begin
            miscompares++; $display("[TB] FAIL reset_count got=%0d exp=0", pending_count);
        end
        vectors++;
        if (write_error !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_error got=%b exp=0", write_error);
        end
        for (int a = 0; a < 32; a += 2) begin
            ra[0] = 5'(a); ra[1] = 5'(a + 1);
            #2;
            vectors++;
            if (rd(0) !== 32'd0 || rd(1) !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_read x%0d/x%0d got=%h/%h exp=0", a, a + 1, rd(0), rd(1));
            end
            vectors++;
            if (read_pending !== 2'b00) begin
                miscompares++; $display("[TB] FAIL reset_pending x%0d got=%b exp=00", a, read_pending);
            end
        end
        tick();
    endtask

    task automatic test_bypass();
        idle();
        set_wr(0, 4'd4, 1'b0, 5'd5, 32'hDEAD_BEEF);
        ra[0] = 5'd5;
        #2;
        vectors++;
        if (rd(0) !== 32'hDEAD_BEEF) begin
            miscompares++; $display("[TB] FAIL bypass_x5 got=%h exp=deadbeef", rd(0));
        end
        tick();
        idle();
        ra[1] = 5'd5;
        #2;
        vectors++;
        if (rd(1) !== 32'hDEAD_BEEF) begin
            miscompares++; $display("[TB] FAIL array_x5 got=%h exp=deadbeef", rd(1));
        end
        tick();
    endtask

    task automatic test_sign_ext();
        idle();
        set_wr(1, 4'd1, 1'b1, 5'd6, 32'h0000_00F0);
        tick();
        idle();
        ra[0] = 5'd6;
        #2;
        vectors++;
        if (rd(0) !== 32'hFFFF_FFF0) begin
            miscompares++; $display("[TB] FAIL sext_byte got=%h exp=fffffff0", rd(0));
        end
        set_wr(1, 4'd1, 1'b0, 5'd6, 32'h1234_56F0);
        tick();
        idle();
        ra[0] = 5'd6;
        #2;
        vectors++;
        if (rd(0) !== 32'h0000_00F0) begin
            miscompares++; $display("[TB] FAIL zext_byte got=%h exp=000000f0", rd(0));
        end
        set_wr(0, 4'd2, 1'b1, 5'd6, 32'h0000_8001);
        #2;
        vectors++;
        if (rd(0) !== 32'hFFFF_8001) begin
            miscompares++; $display("[TB] FAIL sext_half got=%h exp=ffff8001", rd(0));
        end
        tick();
    endtask

    task automatic test_priority();
        idle();
        set_wr(0, 4'd4, 1'b0, 5'd7, 32'h11);
        set_wr(1, 4'd4, 1'b0, 5'd7, 32'h22);
        ra[0] = 5'd7;
        #2;
        vectors++;
        if (rd(0) !== 32'h22) begin
            miscompares++; $display("[TB] FAIL prio_bypass got=%h exp=22", rd(0));
        end
        tick();
        idle();
        set_wr(0, 4'd4, 1'b0, 5'd0, 32'h55);
        ra[0] = 5'd7; ra[1] = 5'd0;
        #2;
        vectors++;
        if (rd(0) !== 32'h22) begin
            miscompares++; $display("[TB] FAIL prio_array got=%h exp=22", rd(0));
        end
        vectors++;
        if (rd(1) !== 32'h0) begin
            miscompares++; $display("[TB] FAIL x0_bypass got=%h exp=0", rd(1));
        end
        tick();
        idle();
        #2;
        vectors++;
        if (rd(0) !== 32'h0) begin
            miscompares++; $display("[TB] FAIL x0_array got=%h exp=0", rd(0));
        end
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        iv = 1'b1; ia = 5'd9;
        ra[0] = 5'd9;
        #2;
        vectors++;
        if (read_pending[0] !== 1'b0) begin
            miscompares++; $display("[TB] FAIL issue_same_cycle got=%b exp=0", read_pending[0]);
        end
        tick();
        idle();
        ra[0] = 5'd9;
        #2;
        vectors++;
        if (read_pending[0] !== 1'b1) begin
            miscompares++; $display("[TB] FAIL issue_pending got=%b exp=1", read_pending[0]);
        end
        vectors++;
        if (pending_count !== 6'd1) begin
            miscompares++; $display("[TB] FAIL issue_count got=%0d exp=1", pending_count);
        end
        set_wr(0, 4'd4, 1'b0, 5'd9, 32'h99);
        #2;
        vectors++;
        if (read_pending[0] !== 1'b0) begin
            miscompares++; $display("[TB] FAIL write_clears got=%b exp=0", read_pending[0]);
        end
        tick();
        vectors++;
        if (pending_count !== 6'd0) begin
            miscompares++; $display("[TB] FAIL clear_count got=%0d exp=0", pending_count);
        end
    endtask

    task automatic test_issue_write_and_error();
        logic [31:0] old4;
        idle();
        iv = 1'b1; ia = 5'd3;
        set_wr(1, 4'd4, 1'b0, 5'd3, 32'h33);
        tick();
        idle();
        ra[0] = 5'd3;
        #2;
        vectors++;
        if (read_pending[0] !== 1'b1 || pending_count !== 6'd1) begin
            miscompares++;
            $display("[TB] FAIL issue_and_write got=%b/%0d exp=1/1", read_pending[0], pending_count);
        end
        vectors++;
        if (rd(0) !== 32'h33) begin
            miscompares++; $display("[TB] FAIL issue_and_write_data got=%h exp=33", rd(0));
        end
        set_wr(0, 4'd4, 1'b0, 5'd4, 32'hABCD_0004);
        tick();
        idle();
        old4 = 32'hABCD_0004;
        set_wr(0, 4'd3, 1'b0, 5'd4, 32'h7777_7777);
        set_wr(1, 4'd3, 1'b0, 5'd3, 32'h8888_8888);
        ra[0] = 5'd4; ra[1] = 5'd3;
        #2;
        vectors++;
        if (rd(0) !== old4 || read_pending[1] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL illegal_bypass got=%h/%b exp=%h/1", rd(0), read_pending[1], old4);
        end
        tick();
        vectors++;
        if (write_error !== 1'b1) begin
            miscompares++; $display("[TB] FAIL error_pulse got=%b exp=1", write_error);
        end
        idle();
        ra[0] = 5'd4;
        #2;
        vectors++;
        if (rd(0) !== old4) begin
            miscompares++; $display("[TB] FAIL illegal_dropped got=%h exp=%h", rd(0), old4);
        end
        tick();
        vectors++;
        if (write_error !== 1'b0) begin
            miscompares++; $display("[TB] FAIL error_one_cycle got=%b exp=0", write_error);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle();
            reset = ($urandom_range(0, 49) != 0);
            iv = 1'($urandom);
            ia = 5'($urandom_range(0, 7));
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(0, 3) != 0)
                    set_wr(p, rand_width(), 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            end
            for (int k = 0; k < NR; k++)
                ra[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            #2;
            for (int k = 0; k < NR; k++) begin
                vectors++;
                if (rd(k) !== exp_read(ra[k])) begin
                    miscompares++;
                    $display("[TB] FAIL rand_read c=%0d k=%0d x%0d got=%h exp=%h",
                             c, k, ra[k], rd(k), exp_read(ra[k]));
                end
                vectors++;
                if (read_pending[k] !== exp_pend(ra[k])) begin
                    miscompares++;
                    $display("[TB] FAIL rand_pending c=%0d k=%0d x%0d got=%b exp=%b",
                             c, k, ra[k], read_pending[k], exp_pend(ra[k]));
                end
            end
            tick();
            vectors++;
            if (int'(pending_count) !== m_count) begin
                miscompares++;
                $display("[TB] FAIL rand_count c=%0d got=%0d exp=%0d", c, pending_count, m_count);
            end
            vectors++;
            if (write_error !== m_err) begin
                miscompares++;
                $display("[TB] FAIL rand_error c=%0d got=%b exp=%b", c, write_error, m_err);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_pend[r] = 1'b0; end
        m_count = 0;
        m_err   = 1'b0;
        idle();
        reset = 1'b0;
        tick();
        tick();
        $display("[TB] starting directed scenarios");
        test_reset();
        test_bypass();
        test_sign_ext();
        test_priority();
        test_scoreboard();
        test_issue_write_and_error();
        $display("[TB] starting randomized traffic");
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
